// File: rtl/cov_sink.sv
// cov_sink: terminal consumer stage for the dut chain.
// Buffers every valid transaction (in_cmd=1) in a small FIFO drained by a
// ready/valid handshake, and tracks unique coverage over all {adr,data} bins.
// Optional feature: define COV_SINK_DUP_CNT_EN to add the 16-bit dup_cnt
// output, which counts samples that landed on an already-covered bin.
// All FIFO head outputs and coverage outputs come straight from registers.
module cov_sink #(
  parameter int ADR_W  = 2,
  parameter int DATA_W = 3,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_cmd,
  input  logic [ADR_W-1:0]          in_adr,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      clear,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADR_W-1:0]          out_adr,
  output logic [DATA_W-1:0]         out_data,
  output logic                      new_bin,
  output logic [ADR_W+DATA_W:0]     uniq_cnt,
  output logic                      all_hit,
  output logic                      overflow
`ifdef COV_SINK_DUP_CNT_EN
  ,
  output logic [15:0]               dup_cnt
`endif
);

  localparam int BIN_W = ADR_W + DATA_W;
  localparam int NBINS = 1 << BIN_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [BIN_W:0]   UNIQ_ONE  = {{BIN_W{1'b0}}, 1'b1};
  localparam logic [BIN_W:0]   UNIQ_ALL  = (BIN_W+1)'(NBINS);
  localparam logic [BIN_W-1:0] BIN_ZERO  = {BIN_W{1'b0}};

  // FIFO storage and control
  logic [BIN_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             out_valid_r;
  logic [BIN_W-1:0] head_r;

  // Coverage state
  logic [NBINS-1:0] bitmap_r;
  logic [BIN_W:0]   uniq_cnt_r;
  logic             new_bin_r;
  logic             all_hit_r;
  logic             overflow_r;

  // Combinational next-state helpers
  logic [BIN_W-1:0] bin_s;
  logic             pop_s;
  logic             full_s;
  logic             push_ok_s;
  logic             drop_s;
  logic [CNT_W-1:0] count_next_s;
  logic [PTR_W-1:0] rd_ptr_next_s;
  logic [BIN_W-1:0] head_next_s;
  logic             seen_s;
  logic             sample_new_s;
  logic             sample_dup_s;
  logic [BIN_W:0]   uniq_next_s;

  // FIFO push/pop decisions, next occupancy and the next head entry
  always_comb begin
    bin_s         = {in_adr, in_data};
    pop_s         = out_valid_r && out_ready;
    full_s        = (count_r == CNT_FULL);
    push_ok_s     = in_cmd && (!full_s || pop_s);
    drop_s        = in_cmd && full_s && !pop_s;
    count_next_s  = count_r;
    rd_ptr_next_s = rd_ptr_r;
    head_next_s   = BIN_ZERO;
    if (push_ok_s && !pop_s) begin
      count_next_s = count_r + CNT_ONE;
    end else if (pop_s && !push_ok_s) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
    if (pop_s) begin
      rd_ptr_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end
    // The freshly pushed sample becomes the head when nothing older remains.
    if (count_next_s == CNT_ZERO) begin
      head_next_s = BIN_ZERO;
    end else if ((count_r == CNT_ZERO) || (pop_s && (count_r == CNT_ONE))) begin
      head_next_s = bin_s;
    end else begin
      head_next_s = mem_r[rd_ptr_next_s];
    end
  end

  // Coverage classification of the current sample; clear blocks counting
  always_comb begin
    seen_s       = bitmap_r[bin_s];
    sample_new_s = 1'b0;
    sample_dup_s = 1'b0;
    uniq_next_s  = uniq_cnt_r;
    if (in_cmd && !clear) begin
      sample_new_s = !seen_s;
      sample_dup_s = seen_s;
    end else begin
      sample_new_s = 1'b0;
      sample_dup_s = 1'b0;
    end
    if (sample_new_s) begin
      uniq_next_s = uniq_cnt_r + UNIQ_ONE;
    end else begin
      uniq_next_s = uniq_cnt_r;
    end
  end

  // FIFO registers: storage, pointers, occupancy and registered head outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= BIN_ZERO;
      end
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      out_valid_r <= 1'b0;
      head_r      <= BIN_ZERO;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= bin_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != CNT_ZERO);
      head_r      <= head_next_s;
    end
  end

  // Coverage registers: bitmap, unique count, pulses and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_r   <= {NBINS{1'b0}};
      uniq_cnt_r <= {(BIN_W+1){1'b0}};
      new_bin_r  <= 1'b0;
      all_hit_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else if (clear) begin
      bitmap_r   <= {NBINS{1'b0}};
      uniq_cnt_r <= {(BIN_W+1){1'b0}};
      new_bin_r  <= 1'b0;
      all_hit_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (sample_new_s) begin
        bitmap_r[bin_s] <= 1'b1;
      end
      uniq_cnt_r <= uniq_next_s;
      new_bin_r  <= sample_new_s;
      all_hit_r  <= (uniq_next_s == UNIQ_ALL);
      overflow_r <= overflow_r | drop_s;
    end
  end

`ifdef COV_SINK_DUP_CNT_EN
  logic [15:0] dup_cnt_r;

  // Saturating count of samples that hit an already-covered bin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_cnt_r <= 16'h0000;
    end else if (clear) begin
      dup_cnt_r <= 16'h0000;
    end else if (sample_dup_s && (dup_cnt_r != 16'hFFFF)) begin
      dup_cnt_r <= dup_cnt_r + 16'h0001;
    end else begin
      dup_cnt_r <= dup_cnt_r;
    end
  end

  assign dup_cnt = dup_cnt_r;
`endif

  assign out_valid = out_valid_r;
  assign out_adr   = head_r[BIN_W-1:DATA_W];
  assign out_data  = head_r[DATA_W-1:0];
  assign new_bin   = new_bin_r;
  assign uniq_cnt  = uniq_cnt_r;
  assign all_hit   = all_hit_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_cov_sink.sv
// Self-checking bench for cov_sink. A queue/bin-array model derived from the
// behavioural rules predicts every output; stimulus mixes directed scenarios
// and $urandom traffic. Define COV_SINK_DUP_CNT_EN to also check dup_cnt.
module tb_cov_sink;
  localparam int ADR_W = 2, DATA_W = 3, DEPTH = 4, NB = 32;

  logic clk = 1'b0, rst = 1'b1, in_cmd = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [1:0] in_adr = 2'd0;
  logic [2:0] in_data = 3'd0;
  logic out_valid, new_bin, all_hit, overflow;
  logic [1:0] out_adr;
  logic [2:0] out_data;
  logic [5:0] uniq_cnt;
`ifdef COV_SINK_DUP_CNT_EN
  logic [15:0] dup_cnt;
`endif

  int checks = 0, fails = 0;

  // reference model
  logic [4:0] q[$];
  bit seen[NB];
  int m_uniq, m_dup;
  bit m_nb, m_ovf;

  cov_sink #(.ADR_W(ADR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_cmd(in_cmd), .in_adr(in_adr), .in_data(in_data),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_adr(out_adr), .out_data(out_data), .new_bin(new_bin),
    .uniq_cnt(uniq_cnt), .all_hit(all_hit), .overflow(overflow)
`ifdef COV_SINK_DUP_CNT_EN
    , .dup_cnt(dup_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    foreach (seen[i]) seen[i] = 1'b0;
    m_uniq = 0; m_dup = 0; m_nb = 1'b0; m_ovf = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, return #1 after the edge.
  task automatic drive(input logic cmd, input logic [1:0] a, input logic [2:0] d,
                       input logic rdy, input logic clr);
    bit pop, full;
    in_cmd = cmd; in_adr = a; in_data = d; out_ready = rdy; clear = clr;
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == DEPTH);
    if (pop) void'(q.pop_front());
    if (cmd) begin
      if (!full || pop) q.push_back({a, d});
      else m_ovf = 1'b1;
    end
    if (clr) begin
      foreach (seen[i]) seen[i] = 1'b0;
      m_uniq = 0; m_nb = 1'b0; m_ovf = 1'b0; m_dup = 0;
    end else if (cmd) begin
      if (!seen[{a, d}]) begin
        seen[{a, d}] = 1'b1; m_uniq++; m_nb = 1'b1;
      end else begin
        m_nb = 1'b0;
        if (m_dup < 65535) m_dup++;
      end
    end else begin
      m_nb = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_cmd = 1'b1; in_adr = 2'd3; in_data = 3'd7; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b exp 0", out_valid); end
    checks++; if ({out_adr, out_data} !== 5'd0) begin fails++; $display("FAIL rst_head: got %0h exp 0", {out_adr, out_data}); end
    checks++; if ({new_bin, all_hit, overflow, uniq_cnt} !== 9'd0) begin fails++; $display("FAIL rst_cov: got %0h exp 0", {new_bin, all_hit, overflow, uniq_cnt}); end
    in_cmd = 1'b0; rst = 1'b0;
    model_reset();
    repeat (10) drive(1'b0, 2'd1, 3'd1, 1'b0, 1'b0);
    checks++; if ({out_valid, new_bin, all_hit, overflow, uniq_cnt} !== 10'd0) begin fails++; $display("FAIL idle: got %0h exp 0", {out_valid, new_bin, all_hit, overflow, uniq_cnt}); end
  endtask

  task automatic test_single();
    drive(1'b1, 2'd1, 3'd5, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %0b exp 1", out_valid); end
    checks++; if ({out_adr, out_data} !== {2'd1, 3'd5}) begin fails++; $display("FAIL single_head: got %0h exp %0h", {out_adr, out_data}, {2'd1, 3'd5}); end
    checks++; if (new_bin !== 1'b1 || uniq_cnt !== 6'd1) begin fails++; $display("FAIL single_cov: got nb=%0b u=%0d exp nb=1 u=1", new_bin, uniq_cnt); end
    drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || new_bin !== 1'b0) begin fails++; $display("FAIL single_after: got v=%0b nb=%0b exp 0 0", out_valid, new_bin); end
  endtask

  task automatic test_repeat_hit();
    drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    drive(1'b1, 2'd2, 3'd3, 1'b1, 1'b0);
    checks++; if (new_bin !== 1'b1 || uniq_cnt !== 6'd1) begin fails++; $display("FAIL rep_first: got nb=%0b u=%0d exp nb=1 u=1", new_bin, uniq_cnt); end
    drive(1'b1, 2'd2, 3'd3, 1'b1, 1'b0);
    checks++; if (new_bin !== 1'b0 || uniq_cnt !== 6'd1) begin fails++; $display("FAIL rep_second: got nb=%0b u=%0d exp nb=0 u=1", new_bin, uniq_cnt); end
`ifdef COV_SINK_DUP_CNT_EN
    checks++; if (dup_cnt !== 16'd1) begin fails++; $display("FAIL rep_dup: got %0d exp 1", dup_cnt); end
`endif
    repeat (3) drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    int popped = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, 2'(i), 3'(i + 2), 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %0b exp 1", overflow); end
    checks++; if (out_valid !== 1'b1 || {out_adr, out_data} !== {2'd0, 3'd2}) begin fails++; $display("FAIL ovf_head: got v=%0b %0h exp v=1 %0h", out_valid, {out_adr, out_data}, {2'd0, 3'd2}); end
    // clear leaves FIFO intact; then pop+push while full must not overflow
    drive(1'b0, 2'd0, 3'd0, 1'b0, 1'b1);
    checks++; if (overflow !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL ovf_clear: got o=%0b v=%0b exp o=0 v=1", overflow, out_valid); end
    drive(1'b1, 2'd3, 3'd7, 1'b1, 1'b0);
    checks++; if (overflow !== 1'b0 || q.size() != DEPTH) begin fails++; $display("FAIL ovf_fullpush: got o=%0b n=%0d exp o=0 n=%0d", overflow, q.size(), DEPTH); end
    checks++; if ({out_adr, out_data} !== {2'd1, 3'd3}) begin fails++; $display("FAIL ovf_head2: got %0h exp %0h", {out_adr, out_data}, {2'd1, 3'd3}); end
    for (int i = 0; i < 6; i++) begin
      if (q.size() > 0) popped++;
      drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
      checks++;
      if (out_valid !== (q.size() > 0) || {out_adr, out_data} !== ((q.size() > 0) ? q[0] : 5'd0)) begin
        fails++; $display("FAIL ovf_drain%0d: got v=%0b %0h exp v=%0b %0h", i, out_valid, {out_adr, out_data}, (q.size() > 0), (q.size() > 0) ? q[0] : 5'd0);
      end
    end
    checks++; if (popped != DEPTH) begin fails++; $display("FAIL ovf_popcount: got %0d exp %0d", popped, DEPTH); end
  endtask

  task automatic test_full_cov();
    drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    for (int b = 0; b < NB; b++) begin
      drive(1'b1, 2'(b >> 3), 3'(b), 1'b1, 1'b0);
      checks++;
      if (uniq_cnt !== 6'(b + 1) || all_hit !== (b == NB - 1) || new_bin !== 1'b1) begin
        fails++; $display("FAIL sweep%0d: got u=%0d ah=%0b nb=%0b exp u=%0d ah=%0b nb=1", b, uniq_cnt, all_hit, new_bin, b + 1, (b == NB - 1));
      end
    end
    drive(1'b1, 2'd3, 3'd7, 1'b1, 1'b0);
    checks++; if (uniq_cnt !== 6'd32 || all_hit !== 1'b1 || new_bin !== 1'b0) begin fails++; $display("FAIL sweep_sat: got u=%0d ah=%0b nb=%0b exp 32 1 0", uniq_cnt, all_hit, new_bin); end
    drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 150; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(1, 2)), 3'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (uniq_cnt !== 6'(m_uniq) || m_uniq > 16 || all_hit !== 1'b0 || new_bin !== m_nb) begin
        fails++; $display("FAIL partial%0d: got u=%0d ah=%0b nb=%0b exp u=%0d ah=0 nb=%0b", i, uniq_cnt, all_hit, new_bin, m_uniq, m_nb);
      end
    end
  endtask

  task automatic test_clear_collision();
    repeat (6) drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 2'd1, 3'd0, 1'b0, 1'b1);
    checks++; if (uniq_cnt !== 6'd0 || overflow !== 1'b0 || new_bin !== 1'b0) begin fails++; $display("FAIL clr_cov: got u=%0d o=%0b nb=%0b exp 0 0 0", uniq_cnt, overflow, new_bin); end
    checks++; if (out_valid !== 1'b1 || {out_adr, out_data} !== {2'd1, 3'd0}) begin fails++; $display("FAIL clr_fifo: got v=%0b %0h exp v=1 %0h", out_valid, {out_adr, out_data}, {2'd1, 3'd0}); end
    drive(1'b1, 2'd1, 3'd0, 1'b1, 1'b0);
    checks++; if (new_bin !== 1'b1 || uniq_cnt !== 6'd1) begin fails++; $display("FAIL clr_after: got nb=%0b u=%0d exp 1 1", new_bin, uniq_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 31) == 0));
      checks++;
      if (out_valid !== (q.size() > 0) || {out_adr, out_data} !== ((q.size() > 0) ? q[0] : 5'd0) ||
          uniq_cnt !== 6'(m_uniq) || new_bin !== m_nb || overflow !== m_ovf || all_hit !== (m_uniq == NB)) begin
        fails++; $display("FAIL rand%0d: got v=%0b h=%0h u=%0d nb=%0b o=%0b ah=%0b exp v=%0b h=%0h u=%0d nb=%0b o=%0b", i,
          out_valid, {out_adr, out_data}, uniq_cnt, new_bin, overflow, all_hit, (q.size() > 0), (q.size() > 0) ? q[0] : 5'd0, m_uniq, m_nb, m_ovf);
      end
`ifdef COV_SINK_DUP_CNT_EN
      checks++; if (dup_cnt !== 16'(m_dup)) begin fails++; $display("FAIL rand_dup%0d: got %0d exp %0d", i, dup_cnt, m_dup); end
`endif
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 2'(i), 3'(i), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if ({out_valid, out_adr, out_data, new_bin, all_hit, overflow, uniq_cnt} !== 15'd0) begin fails++; $display("FAIL midrst_async: got %0h exp 0", {out_valid, out_adr, out_data, new_bin, all_hit, overflow, uniq_cnt}); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    drive(1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0 || uniq_cnt !== 6'd0) begin fails++; $display("FAIL midrst_after: got v=%0b u=%0d exp 0 0", out_valid, uniq_cnt); end
`ifdef COV_SINK_DUP_CNT_EN
    checks++; if (dup_cnt !== 16'd0) begin fails++; $display("FAIL midrst_dup: got %0d exp 0", dup_cnt); end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_repeat_hit();
    test_overflow();
    test_full_cov();
    test_clear_collision();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cov_sink.md
Name: cov_sink

Overview:
- Terminal consumer stage placed directly downstream of the last dut in the chain, on the cmd/adr/data master side of the final dut_if.
- Captures every valid transaction (cmd=1) into a small FIFO, drained by a downstream ready/valid handshake.
- Keeps a unique-coverage bitmap over all {adr,data} combinations and reports unique-bin count, new-bin pulse and full-coverage flag.

Parameters:
- ADR_W, 2, width of adr field
- DATA_W, 3, width of data field
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- in_cmd  input  1  transaction valid from upstream dut master side; no backpressure upstream
- in_adr  input  ADR_W  transaction address
- in_data  input  DATA_W  transaction data
- clear  input  1  synchronous clear of coverage state and overflow
- out_valid  output  1  FIFO head valid
- out_ready  input  1  downstream accepts head
- out_adr  output  ADR_W  head address
- out_data  output  DATA_W  head data
- new_bin  output  1  one-cycle pulse: previous sample hit an unseen bin
- uniq_cnt  output  ADR_W+DATA_W+1  number of distinct bins hit
- all_hit  output  1  high when uniq_cnt == 2**(ADR_W+DATA_W)
- overflow  output  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset (async, rst=1): FIFO empty, out_valid=0, out_adr=0, out_data=0, bitmap all 0, uniq_cnt=0, new_bin=0, all_hit=0, overflow=0. Outputs hold reset values while rst is high. Release is synchronous to the next clk edge.
- Sample: in_cmd=1 at a clk edge is one transaction. in_cmd=0 means no transaction, and adr/data are ignored.
- Bin index = {in_adr, in_data}. Total bins B = 2**(ADR_W+DATA_W).
- Coverage update takes effect on the sampling edge and is visible the following cycle:
  - Unseen bin: set bitmap bit, increment uniq_cnt, assert new_bin for exactly one cycle.
  - Seen bin: no change, new_bin=0.
- all_hit is registered and asserts in the same cycle uniq_cnt reaches B. uniq_cnt never exceeds B.
- FIFO push happens on every sample.
  - Not full: enqueue. out_valid rises one cycle after the sampling edge, so minimum latency is 1 cycle.
  - Full and out_ready=0 in the same cycle: sample dropped, overflow set (sticky). Coverage is still updated.
  - Full and out_ready=1 in the same cycle: pop and push both succeed, and the count stays at DEPTH.
- Pop: out_valid && out_ready at an edge removes the head. out_adr/out_data always show the head entry and are 0 when empty.
- Empty with push and no pop: count becomes 1. Push on an empty FIFO never bypasses to the output in the same cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from an occupancy count of log2(DEPTH)+1 bits.
- clear=1 at an edge zeroes bitmap, uniq_cnt, all_hit, new_bin and overflow. FIFO contents and pointers are untouched.
- clear with a simultaneous sample: clear wins for coverage (sample not counted, new_bin=0), but the sample is still pushed to the FIFO.
- rst mid-operation: all state returns to reset values immediately, and FIFO contents are discarded.

Optional Feature:
- Macro: COV_SINK_DUP_CNT_EN.
- Defined: adds output dup_cnt (16 bits). It increments on each sample whose bin was already set, saturates at 16'hFFFF, and is zeroed by rst and clear. A sample blocked by clear is not counted.
- Undefined: port and counter absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, in_cmd=0 for 10 cycles -> all outputs 0, out_valid=0.
- Single txn: in_cmd=1, adr=1, data=5, out_ready=1, one cycle -> next cycle out_valid=1, out_adr=1, out_data=5, new_bin=1, uniq_cnt=1. Following cycle: out_valid=0, new_bin=0.
- Repeat hit: adr=2, data=3 sent twice -> uniq_cnt=1 after both, new_bin pulses only after the first. With COV_SINK_DUP_CNT_EN, dup_cnt=1.
- Overflow: out_ready=0, 5 consecutive samples with DEPTH=4 -> 4 entries held, overflow=1. Then out_ready=1 drains exactly the first 4 in order. Full+pop+push in the same cycle keeps the count at 4 and does not set overflow.
- Full coverage: sweep all 32 {adr 0..3, data 0..7} once -> uniq_cnt=32, all_hit=1 in the cycle after the last sample. Random traffic restricted to adr 1..2 only reaches uniq_cnt≤16 and all_hit=0.
- Clear collision: clear=1 with a sample of adr=1, data=0 on the same edge -> uniq_cnt=0, overflow=0, new_bin=0, but the FIFO holds the entry (out_valid=1).
